// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader and the instruction
// memory it fills: default memory depth, loader FSM state encodings and a
// word-index to byte-address helper.
package imem_loader_pkg;

  // Instruction memory depth in 32-bit words.
  localparam int MEM_WORDS_DEFAULT = 32;

  // Loader FSM states. The encoding is also visible on the loader's
  // state_dbg output, so keep these values stable.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_BYTES = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } state_t;

  // Word index -> word-aligned byte address (bits [1:0] always zero).
  function automatic logic [31:0] word_addr(input logic [29:0] idx);
    return {idx, 2'b00};
  endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// byte_packer: collects four serial bytes into one 32-bit word, MSB first
// (the first byte loaded ends up in word_o[31:24]).
//
// Ports:
//   clock, reset_n  - clock and asynchronous active-low reset
//   clear_i         - drop any partial word and restart at byte 0
//   load_i          - shift byte_i in this cycle
//   byte_i          - serial byte
//   word_o          - assembled word (complete on the cycle after word_full_o)
//   word_full_o     - this load_i completes a word (combinational)
module byte_packer (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        clear_i,
  input  logic        load_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_full_o
);

  logic [1:0]  cnt_q;
  logic [31:0] word_q;

  // The 2-bit counter wraps to 0 on the fourth byte, ready for the next word.
  assign word_full_o = load_i && (cnt_q == 2'd3);
  assign word_o      = word_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= 2'd0;
      word_q <= 32'd0;
    end else if (clear_i) begin
      cnt_q  <= 2'd0;
      word_q <= 32'd0;
    end else if (load_i) begin
      cnt_q  <= cnt_q + 2'd1;
      word_q <= {word_q[23:0], byte_i};
    end
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: receives a program image over a byte stream and writes it
// into instruction memory while holding the processor.
//
// Stream format: one header byte N (word count, 1..MEM_WORDS), then N
// 32-bit words, each sent MSB first.
//
// Handshake: byte_in is consumed on a rising edge where byte_valid and
// byte_ready are both high; byte_valid may drop for any number of cycles,
// and bytes offered while byte_ready is low stay with the sender.
//
// Ports:
//   clock, reset_n  - clock and asynchronous active-low reset
//   start           - pulse: begin a load session (from IDLE, DONE or ERR)
//   abort           - pulse: cancel an active session -> ERR
//   byte_in         - serial program byte
//   byte_valid      - byte_in valid
//   byte_ready      - loader accepts byte_in
//   wr_en           - one-cycle instruction memory write strobe
//   wr_addr         - word-aligned byte address of the write
//   wr_data         - instruction word
//   cpu_hold        - keep the processor fetch stage stalled
//   done            - image loaded (level)
//   error           - bad header or aborted (level)
//   state_dbg       - current FSM state (state_t encoding)
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int MEM_WORDS = MEM_WORDS_DEFAULT
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic        abort,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        cpu_hold,
  output logic        done,
  output logic        error,
  output logic [2:0]  state_dbg
);

  localparam int          IDX_W = $clog2(MEM_WORDS) + 1;
  localparam logic [31:0] MAX_N = 32'(MEM_WORDS);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;

  logic byte_ready_q;
  logic wr_en_q;
  logic cpu_hold_q;
  logic done_q;
  logic error_q;

  logic        xfer;
  logic        hdr_bad;
  logic        last_word;
  logic        pk_load;
  logic        pk_clear;
  logic        pk_full;
  logic [31:0] pk_word;

  assign xfer      = byte_valid && byte_ready_q;
  assign hdr_bad   = (byte_in == 8'd0) || ({24'd0, byte_in} > MAX_N);
  assign last_word = (idx_q == (cnt_q - IDX_W'(1)));

  // Abort wins over a byte arriving in the same cycle, so that byte is
  // never shifted into the word.
  assign pk_load  = (state_q == ST_BYTES) && xfer && !abort;
  assign pk_clear = start && ((state_q == ST_IDLE) || (state_q == ST_DONE) ||
                              (state_q == ST_ERR));

  byte_packer u_byte_packer (
    .clock       (clock),
    .reset_n     (reset_n),
    .clear_i     (pk_clear),
    .load_i      (pk_load),
    .byte_i      (byte_in),
    .word_o      (pk_word),
    .word_full_o (pk_full)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d = ST_HDR;
          idx_d   = '0;
        end
      end
      ST_HDR: begin
        if (abort) begin
          state_d = ST_ERR;
        end else if (xfer) begin
          if (hdr_bad) begin
            state_d = ST_ERR;
          end else begin
            cnt_d   = IDX_W'(byte_in);
            idx_d   = '0;
            state_d = ST_BYTES;
          end
        end
      end
      ST_BYTES: begin
        if (abort) begin
          state_d = ST_ERR;
        end else if (pk_full) begin
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (abort) begin
          state_d = ST_ERR;
        end else if (last_word) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = ST_BYTES;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered by decoding the next state, so each output
  // matches the state the FSM is in during that cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      byte_ready_q <= 1'b0;
      wr_en_q      <= 1'b0;
      cpu_hold_q   <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      byte_ready_q <= (state_d == ST_HDR) || (state_d == ST_BYTES);
      wr_en_q      <= (state_d == ST_WRITE);
      cpu_hold_q   <= (state_d == ST_HDR) || (state_d == ST_BYTES) ||
                      (state_d == ST_WRITE) || (state_d == ST_ERR);
      done_q       <= (state_d == ST_DONE);
      error_q      <= (state_d == ST_ERR);
    end
  end

  assign byte_ready = byte_ready_q;
  // An abort arriving during the WRITE cycle must still cancel that write,
  // so the registered strobe is masked by abort on the way out.
  assign wr_en      = wr_en_q && !abort;
  assign wr_addr    = word_addr(30'(idx_q));
  assign wr_data    = pk_word;
  assign cpu_hold   = cpu_hold_q;
  assign done       = done_q;
  assign error      = error_q;
  assign state_dbg  = state_q;

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter MEM_WORDS, default 32, instruction memory depth in words; legal count range is 1..MEM_WORDS.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  single-cycle pulse that begins a load session.
REQ-005 abort  input  1  single-cycle pulse that cancels an active session.
REQ-006 byte_in  input  8  serial program byte.
REQ-007 byte_valid  input  1  byte_in is valid this cycle.
REQ-008 byte_ready  output  1  loader accepts byte_in this cycle; a transfer occurs when byte_valid && byte_ready.
REQ-009 wr_en  output  1  one-cycle write strobe to instruction memory.
REQ-010 wr_addr  output  32  word-aligned byte address (bits [1:0] = 0).
REQ-011 wr_data  output  32  instruction word.
REQ-012 cpu_hold  output  1  holds the processor PC/fetch stage while asserted.
REQ-013 done  output  1  load completed successfully (level).
REQ-014 error  output  1  load failed or aborted (level).

Function
REQ-015 States: IDLE, HDR, BYTES, WRITE, DONE, ERR; all outputs registered.
REQ-016 IDLE: byte_ready=0, cpu_hold=0; start -> HDR.
REQ-017 HDR: byte_ready=1, cpu_hold=1; accepted byte = word count N; N==0 or N>MEM_WORDS -> ERR, else latch N, clear word index, -> BYTES.
REQ-018 BYTES: byte_ready=1; shift bytes MSB-first (first byte -> wr_data[31:24]); 4th accepted byte -> WRITE.
REQ-019 WRITE: byte_ready=0, wr_en=1 for exactly one cycle, wr_addr = index*4; index==N-1 -> DONE, else index+1 -> BYTES.
REQ-020 Latency: 4th byte accepted on edge k -> wr_en high during cycle k+1 with final wr_data.
REQ-021 DONE: done=1, cpu_hold=0, byte_ready=0, held until start (-> HDR, done cleared).
REQ-022 ERR: error=1, cpu_hold=1 (processor held on partial image), held until start (-> HDR, error cleared) or reset.
REQ-023 start while in HDR, BYTES or WRITE is ignored.
REQ-024 abort in HDR/BYTES/WRITE -> ERR next cycle; abort has priority over a same-cycle byte transfer or write (wr_en suppressed); abort in IDLE/DONE/ERR ignored.
REQ-025 Bytes presented while byte_ready=0 are not consumed; byte_valid gaps of any length are tolerated without state change.
REQ-026 wr_addr never exceeds (MEM_WORDS-1)*4; the index does not wrap within a session.

Reset
REQ-027 reset_n low asynchronously forces IDLE, index=0, N=0, wr_data=0, wr_addr=0, and all 1-bit outputs to 0.
REQ-028 Reset mid-session discards the partial word; no wr_en is issued after reset assertion.

Structure
REQ-029 MEM_WORDS default and state encodings live in the shared MIPS definitions include, also used by the instruction memory.
REQ-030 The byte-to-word shift register with a 2-bit byte counter is a sub-module named byte_packer (load, clear, word_full outputs).
REQ-031 Index and count widths derive from $clog2(MEM_WORDS)+1.

Verification
REQ-032 start, bytes 02,20,08,00,05,00,00,00,00 -> wr_en at wr_addr 0x0 data 0x20080005, then 0x4 data 0x00000000; done=1, cpu_hold=0.
REQ-033 start, header 0x00, then header 0x21 (MEM_WORDS=32) -> error=1, cpu_hold=1, no wr_en.
REQ-034 N=1, byte_valid toggled every other cycle across 4 data bytes -> exactly one wr_en, correct word, no dropped/duplicated byte.
REQ-035 N=3, abort asserted the same cycle as the second word's WRITE -> no wr_en at 0x4, error=1; a new start then a 1-word load -> done=1, error=0.
REQ-036 reset_n low during BYTES of word 1, then released -> IDLE, all outputs 0; next session writes from 0x0.
REQ-037 start pulsed during BYTES -> ignored; session completes with the original N.
